// File: rtl/counter_sched_if.sv
// counter_sched_if: bundles the requester handshake and the shared-counter link.
//   req          requester -> scheduler, level request per requester
//   req_val      requester -> scheduler, start values, requester i at [i*WIDTH +: WIDTH]
//   gnt          scheduler -> requester, one-hot grant
//   done         scheduler -> requester, one-cycle completion pulse
//   busy         scheduler -> requester, high whenever a job is in flight
//   cnt_load     scheduler -> counter, load strobe
//   cnt_load_val scheduler -> counter, start value to load
//   cnt_count    counter -> scheduler, current count
interface counter_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_val;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic                   cnt_load;
    logic [WIDTH-1:0]       cnt_load_val;
    logic [WIDTH-1:0]       cnt_count;
    modport master (
        output req, req_val, cnt_count,
        input  gnt, done, busy, cnt_load, cnt_load_val
    );
    modport slave (
        input  req, req_val, cnt_count,
        output gnt, done, busy, cnt_load, cnt_load_val
    );
endinterface

// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler sharing one loadable up-counter between requesters.
//   clk  clock, rising edge
//   rst  synchronous reset, active-high
//   bus  slave side of counter_sched_if (req/req_val in, gnt/done/busy out,
//        cnt_load/cnt_load_val to the counter, cnt_count from the counter)
module counter_sched #(
    parameter int               N_REQ = 4,
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TERM  = {WIDTH{1'b1}}
) (
    input logic              clk,
    input logic              rst,
    counter_sched_if.slave   bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  pick;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % N_REQ);
    endfunction

    // Scan downwards so the requester closest to ptr overwrites the others.
    always_comb begin
        pick = ptr;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (bus.req[wrap(int'(ptr) + k)]) pick = wrap(int'(ptr) + k);
    end

    // Outputs are registered alongside the state so each one follows state/idx exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ptr              <= '0;
            idx              <= '0;
            bus.gnt          <= '0;
            bus.done         <= '0;
            bus.busy         <= 1'b0;
            bus.cnt_load     <= 1'b0;
            bus.cnt_load_val <= '0;
        end else begin
            bus.done <= '0;
            case (state)
                IDLE: if (|bus.req) begin
                    idx              <= pick;
                    bus.cnt_load_val <= bus.req_val[int'(pick)*WIDTH +: WIDTH];
                    bus.gnt          <= N_REQ'(1) << pick;
                    bus.busy         <= 1'b1;
                    bus.cnt_load     <= 1'b1;
                    state            <= LOAD;
                end
                LOAD: begin
                    bus.cnt_load <= 1'b0;
                    if (!bus.req[idx]) begin
                        bus.gnt  <= '0;
                        bus.busy <= 1'b0;
                        ptr      <= wrap(int'(idx) + 1);
                        state    <= IDLE;
                    end else
                        state <= RUN;
                end
                // Abort outranks the terminal-count check.
                RUN: if (!bus.req[idx]) begin
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                    ptr      <= wrap(int'(idx) + 1);
                    state    <= IDLE;
                end else if (bus.cnt_count == TERM) begin
                    bus.done <= bus.gnt;
                    state    <= DONE;
                end
                default: begin
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                    ptr      <= wrap(int'(idx) + 1);
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed bench for counter_sched with a behavioural shared counter.
module tb_counter_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] cnt_q = '0;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    counter_sched_if bus ();
    counter_sched dut (.clk(clk), .rst(rst), .bus(bus));

    always_ff @(posedge clk) cnt_q <= bus.cnt_load ? bus.cnt_load_val : cnt_q + 4'd1;
    assign bus.cnt_count = cnt_q;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.req = '0;
        bus.req_val = '0;
        tick(2);
        rst = 1'b0;
        chk("reset gnt", 32'(bus.gnt), 0);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset cnt_load_val", 32'(bus.cnt_load_val), 0);
        // Single job, start value 12; late req_val edits and a non-winner request are ignored.
        do_reset();
        bus.req_val = 16'h000C;
        bus.req = 4'b0001;
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk($sformatf("t1 gnt c%0d", c), 32'(bus.gnt), (c <= 6) ? 1 : 0);
            chk($sformatf("t1 done c%0d", c), 32'(bus.done), (c == 6) ? 1 : 0);
            chk($sformatf("t1 load c%0d", c), 32'(bus.cnt_load), (c == 1) ? 1 : 0);
            chk($sformatf("t1 busy c%0d", c), 32'(bus.busy), (c <= 6) ? 1 : 0);
            if (c <= 6) chk($sformatf("t1 lval c%0d", c), 32'(bus.cnt_load_val), 12);
            if (c == 1) bus.req_val = 16'h0003;
            if (c == 2) bus.req = 4'b1001;
            if (c == 6) bus.req = 4'b0000;
        end
        chk("t1 ptr", 32'(dut.ptr), 1);
        // Two requesters back to back with one IDLE cycle between jobs.
        do_reset();
        bus.req_val = 16'h0D0E;
        bus.req = 4'b0101;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk($sformatf("t2 gnt c%0d", c), 32'(bus.gnt), (c <= 4) ? 1 : (c == 5) ? 0 : 4);
            chk($sformatf("t2 done c%0d", c), 32'(bus.done), (c == 4) ? 1 : (c == 10) ? 4 : 0);
            chk($sformatf("t2 busy c%0d", c), 32'(bus.busy), (c == 5) ? 0 : 1);
            chk($sformatf("t2 load c%0d", c), 32'(bus.cnt_load), (c == 1 || c == 6) ? 1 : 0);
            if (c == 10) bus.req = '0;
        end
        tick();
        chk("t2 ptr", 32'(dut.ptr), 3);
        chk("t2 idle busy", 32'(bus.busy), 0);
        // All four requesting with start value 15: rotating grants, 4 cycles per job.
        do_reset();
        bus.req_val = 16'hFFFF;
        bus.req = 4'b1111;
        for (int c = 1; c <= 19; c++) begin
            tick();
            chk($sformatf("t3 gnt c%0d", c), 32'(bus.gnt),
                ((c - 1) % 4 < 3) ? (1 << (((c - 1) / 4) % 4)) : 0);
            chk($sformatf("t3 done c%0d", c), 32'(bus.done),
                ((c - 1) % 4 == 2) ? (1 << (((c - 1) / 4) % 4)) : 0);
            if (c == 19) bus.req = '0;
        end
        tick();
        chk("t3 ptr", 32'(dut.ptr), 1);
        // Abort during RUN: back to IDLE with no done, pointer advances past the victim.
        do_reset();
        bus.req_val = 16'h0000;
        bus.req = 4'b0010;
        tick(5);
        chk("t4 gnt run", 32'(bus.gnt), 2);
        bus.req = '0;
        for (int c = 6; c <= 8; c++) begin
            tick();
            chk($sformatf("t4 gnt c%0d", c), 32'(bus.gnt), 0);
            chk($sformatf("t4 done c%0d", c), 32'(bus.done), 0);
            chk($sformatf("t4 busy c%0d", c), 32'(bus.busy), 0);
        end
        chk("t4 ptr", 32'(dut.ptr), 2);
        // Reset mid-RUN clears everything including the pointer.
        bus.req_val = 16'h0900;
        bus.req = 4'b0100;
        tick(3);
        chk("t5 gnt run", 32'(bus.gnt), 4);
        chk("t5 busy run", 32'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = '0;
        chk("t5 gnt", 32'(bus.gnt), 0);
        chk("t5 done", 32'(bus.done), 0);
        chk("t5 busy", 32'(bus.busy), 0);
        chk("t5 load", 32'(bus.cnt_load), 0);
        chk("t5 lval", 32'(bus.cnt_load_val), 0);
        chk("t5 ptr", 32'(dut.ptr), 0);
        tick();
        chk("t5 done after", 32'(bus.done), 0);
        // Start value 0: longest job, done at cycle 18.
        do_reset();
        bus.req_val = 16'h0000;
        bus.req = 4'b0001;
        for (int c = 1; c <= 19; c++) begin
            tick();
            chk($sformatf("t6 gnt c%0d", c), 32'(bus.gnt), (c <= 18) ? 1 : 0);
            chk($sformatf("t6 done c%0d", c), 32'(bus.done), (c == 18) ? 1 : 0);
            chk($sformatf("t6 onehot c%0d", c), 32'($countones(bus.gnt) <= 1), 1);
            if (c == 18) bus.req = '0;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
